// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->MEM pipeline register directly behind the ALU.
// Captures result and control, resolves conditional branches from the ALU
// zero/sign flags, and buffers up to two entries (main + skid) so that MEM
// back-pressure never reaches EX combinationally.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge. in_ready comes straight from a flop. out_* is stable while
// out_valid is high and out_ready is low.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_f,
    input  logic [2:0]        br_type,
    input  logic [DATA_W-1:0] br_target,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_store_data,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [31:0]       retired_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
    } entry_t;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;
    localparam logic [2:0] BR_BLEZ = 3'd5;
    localparam logic [2:0] BR_BGTZ = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    entry_t            r_main;
    entry_t            r_skid;
    entry_t            w_in_entry;
    logic              r_redirect_valid;
    logic [DATA_W-1:0] r_redirect_pc;
    logic [31:0]       r_retired_cnt;

    logic              w_accept;
    logic              w_handoff;
    logic              w_taken;
    logic              w_redirect;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign w_accept   = in_valid & r_in_ready;
    assign w_handoff  = (r_state != ST_EMPTY) & out_ready;
    assign w_redirect = w_accept & w_taken & ~flush;

    // Incoming entry; writes to r0 are dropped here so MEM/WB never see them.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.result     = alu_out;
        w_in_entry.rd         = rd_addr;
        w_in_entry.reg_write  = reg_write & (rd_addr != '0);
        w_in_entry.mem_read   = mem_read;
        w_in_entry.mem_write  = mem_write;
        w_in_entry.store_data = store_data;
    end

    // Branch resolution from the ALU flags of the entry being accepted.
    always_comb begin
        w_taken = 1'b0;
        case (br_type)
            BR_NONE: w_taken = 1'b0;
            BR_BEQ:  w_taken = alu_z;
            BR_BNE:  w_taken = ~alu_z;
            BR_BLTZ: w_taken = alu_f;
            BR_BGEZ: w_taken = ~alu_f;
            BR_BLEZ: w_taken = alu_z | alu_f;
            BR_BGTZ: w_taken = ~alu_z & ~alu_f;
            BR_JUMP: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // Occupancy next-state and register load enables; flush overrides all.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_handoff) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_handoff && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_handoff) begin
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_handoff) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register and registered ready (low only while both slots are held).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Main and skid data registers; main feeds the MEM-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    // One-cycle redirect pulse; the target is held until the next redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= br_target;
            end
        end
    end

    // Retired counter: one per handoff, including a handoff in a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
        end else if (w_handoff) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = (r_state != ST_EMPTY);
    assign out_result     = r_main.result;
    assign out_rd         = r_main.rd;
    assign out_reg_write  = r_main.reg_write;
    assign out_mem_read   = r_main.mem_read;
    assign out_mem_write  = r_main.mem_write;
    assign out_store_data = r_main.store_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign retired_cnt    = r_retired_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by a random run,
// with an expected-entry queue standing in for the two-slot buffer.
module tb_alu_result_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int EW     = DATA_W + RD_W + 3 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out = '0;
    logic              alu_z = 1'b0;
    logic              alu_f = 1'b0;
    logic [2:0]        br_type = '0;
    logic [DATA_W-1:0] br_target = '0;
    logic [RD_W-1:0]   rd_addr = '0;
    logic              reg_write = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [DATA_W-1:0] store_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [DATA_W-1:0] out_store_data;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic [31:0]       retired_cnt;
    logic [1:0]        dbg_state;

    alu_result_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_z(alu_z), .alu_f(alu_f),
        .br_type(br_type), .br_target(br_target),
        .rd_addr(rd_addr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .retired_cnt(retired_cnt), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]     exp_q[$];
    logic              m_ready = 1'b0;
    logic [31:0]       m_cnt = '0;
    logic [DATA_W-1:0] m_pc = '0;
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic taken(input logic [2:0] bt, input logic z, input logic f);
        case (bt)
            3'd1: return z;
            3'd2: return !z;
            3'd3: return f;
            3'd4: return !f;
            3'd5: return z || f;
            3'd6: return !z && !f;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic [31:0] sd,
                        input logic [2:0] bt, input logic [31:0] tgt,
                        input logic z, input logic f);
        in_valid = 1'b1; alu_out = res; rd_addr = rd; reg_write = rw;
        mem_read = mr; mem_write = mw; store_data = sd;
        br_type = bt; br_target = tgt; alu_z = z; alu_f = f;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        br_type = 3'd0;
    endtask

    // Advance one clock: score the handoff/accept about to happen, then check
    // the registered outputs 1 time unit after the edge.
    task automatic step();
        logic          acc;
        logic          hnd;
        logic          tk;
        logic [EW-1:0] e;
        acc = in_valid && m_ready && !flush;
        hnd = (exp_q.size() != 0) && out_ready;
        tk  = acc && taken(br_type, alu_z, alu_f);
        if (hnd) begin
            e = exp_q.pop_front();
            check("out_result", out_result, e[EW-1 -: DATA_W]);
            check("out_rd", {27'd0, out_rd}, {27'd0, e[DATA_W+RD_W+2 -: RD_W]});
            check("out_ctl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
                  {29'd0, e[DATA_W+2 -: 3]});
            check("out_store_data", out_store_data, e[DATA_W-1:0]);
            m_cnt = m_cnt + 32'd1;
        end
        if (flush) exp_q.delete();
        if (acc) exp_q.push_back({alu_out, rd_addr, reg_write && (rd_addr != 5'd0),
                                  mem_read, mem_write, store_data});
        if (tk) m_pc = br_target;
        @(posedge clk);
        #1;
        m_ready = (exp_q.size() < 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, tk});
        check("redirect_pc", redirect_pc, m_pc);
        check("retired_cnt", retired_cnt, m_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_result"}, out_result, 32'd0);
        check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
        check({tag, "_out_ctl"}, {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
        check({tag, "_out_store_data"}, out_store_data, 32'd0);
        check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        check({tag, "_retired_cnt"}, retired_cnt, 32'd0);
        check({tag, "_dbg_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // 1: single add
        out_ready = 1'b1;
        push(32'd5, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("t1_out_result", out_result, 32'd5);
        check("t1_out_rd", {27'd0, out_rd}, 32'd3);
        idle();
        step();

        // 2: back-pressure, A then B fill both slots
        out_ready = 1'b0;
        push(32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        step();
        push(32'd2, 5'd2, 1'b1, 1'b0, 1'b1, 32'hAB, 3'd0, 32'd0, 1'b0, 1'b0);
        step();
        idle();
        held = out_result;
        step();
        step();
        check("t2_stable", out_result, held);
        check("t2_stable_val", out_result, 32'd1);
        out_ready = 1'b1;
        step();
        step();
        step();

        // 3: branches
        push(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd1, 32'h100, 1'b1, 1'b0); step(); // beq taken
        idle(); step();                                                              // pulse drops, pc held
        push(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd2, 32'h200, 1'b1, 1'b0); step(); // bne not taken
        push(32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 3'd5, 32'h300, 1'b0, 1'b1); step(); // blez taken
        push(32'd7, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 3'd6, 32'h400, 1'b0, 1'b0); step(); // bgtz taken
        push(32'd7, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 3'd3, 32'h500, 1'b0, 1'b0); step(); // bltz not taken
        push(32'd9, 5'd6, 1'b0, 1'b0, 1'b0, 32'd0, 3'd7, 32'h600, 1'b0, 1'b0); step(); // jump
        idle(); step(); step();

        // 4: flush while FULL with in_valid, then while ONE with in_valid
        out_ready = 1'b0;
        push(32'h11, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        push(32'h22, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        push(32'h33, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 3'd7, 32'h700, 1'b0, 1'b0);
        flush = 1'b1; step(); flush = 1'b0;
        push(32'h44, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        push(32'h55, 5'd11, 1'b1, 1'b0, 1'b0, 32'd0, 3'd7, 32'h800, 1'b0, 1'b0);
        flush = 1'b1; step(); flush = 1'b0;
        push(32'h66, 5'd12, 1'b1, 1'b1, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1; step();
        idle(); step();

        // 5: rd 0 gating, then reset asserted while FULL
        push(32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        idle(); step();
        out_ready = 1'b0;
        push(32'h88, 5'd13, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        push(32'h99, 5'd14, 1'b1, 1'b0, 1'b0, 32'd0, 3'd7, 32'h900, 1'b0, 1'b0); step();
        idle();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete(); m_cnt = '0; m_pc = '0; m_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // 6: counter wrap
        force dut.r_retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_cnt;
        m_cnt = 32'hFFFF_FFFF;
        push(32'hAA, 5'd15, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0); step();
        idle(); step();
        check("t6_wrap", retired_cnt, 32'd0);

        // Random run; a stalled input holds its payload until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !m_ready)) begin
                if ($urandom_range(0, 2) != 0)
                    push($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                         3'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    idle();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            step();
        end

        // Drain with a bounded budget.
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("drain_timeout", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
